// File: rtl/alu_top.sv
// Registered 16-bit ALU: arithmetic, logic, compare and shift units.
// Flags decode ALU_FUN[3:2]; the selected unit's bus registers, the others clear.
module alu_top #(
  parameter int in_width  = 16,
  parameter int out_width = 16
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [in_width-1:0]  A,
  input  logic [in_width-1:0]  B,
  input  logic [3:0]           ALU_FUN,
  output logic [out_width-1:0] Arith_OUT,
  output logic                 Carry_OUT,
  output logic [out_width-1:0] Logic_OUT,
  output logic [1:0]           CMP_OUT,
  output logic [out_width-1:0] SHIFT_OUT,
  output logic                 Arith_Flag,
  output logic                 Logic_Flag,
  output logic                 CMP_Flag,
  output logic                 SHIFT_Flag
);

  logic [in_width:0]    sum;
  logic [in_width:0]    diff;
  logic [in_width-1:0]  prod;
  logic [in_width-1:0]  quot;

  logic [out_width-1:0] arith_nx;
  logic                 carry_nx;
  logic [out_width-1:0] logic_nx;
  logic [1:0]           cmp_nx;
  logic [out_width-1:0] shift_nx;

  assign Arith_Flag = (ALU_FUN[3:2] == 2'b00);
  assign Logic_Flag = (ALU_FUN[3:2] == 2'b01);
  assign CMP_Flag   = (ALU_FUN[3:2] == 2'b10);
  assign SHIFT_Flag = (ALU_FUN[3:2] == 2'b11);

  assign sum  = {1'b0, A} + {1'b0, B};
  assign diff = {1'b0, A} - {1'b0, B};
  assign prod = A * B;
  // Divide by zero yields 0 instead of X.
  assign quot = (B == '0) ? '0 : A / B;

  always_comb begin
    arith_nx = '0;
    carry_nx = 1'b0;
    logic_nx = '0;
    cmp_nx   = 2'd0;
    shift_nx = '0;
    case (ALU_FUN)
      4'b0000: begin
        arith_nx = out_width'(sum[in_width-1:0]);
        carry_nx = sum[in_width];
      end
      4'b0001: begin
        arith_nx = out_width'(diff[in_width-1:0]);
        carry_nx = diff[in_width];
      end
      4'b0010: arith_nx = out_width'(prod);
      4'b0011: arith_nx = out_width'(quot);
      4'b0100: logic_nx = out_width'(A & B);
      4'b0101: logic_nx = out_width'(A | B);
      4'b0110: logic_nx = out_width'(~(A & B));
      4'b0111: logic_nx = out_width'(~(A | B));
      4'b1000: cmp_nx   = 2'd0;
      4'b1001: cmp_nx   = (A == B) ? 2'd1 : 2'd0;
      4'b1010: cmp_nx   = (A > B)  ? 2'd2 : 2'd0;
      4'b1011: cmp_nx   = (A < B)  ? 2'd3 : 2'd0;
      4'b1100: shift_nx = out_width'(A >> 1);
      4'b1101: shift_nx = out_width'(A << 1);
      4'b1110: shift_nx = out_width'(B >> 1);
      4'b1111: shift_nx = out_width'(B << 1);
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      Arith_OUT <= '0;
      Carry_OUT <= 1'b0;
      Logic_OUT <= '0;
      CMP_OUT   <= 2'd0;
      SHIFT_OUT <= '0;
    end else begin
      Arith_OUT <= arith_nx;
      Carry_OUT <= carry_nx;
      Logic_OUT <= logic_nx;
      CMP_OUT   <= cmp_nx;
      SHIFT_OUT <= shift_nx;
    end
  end

endmodule

// File: tb/tb_alu_top.sv
// Directed bench for alu_top: hand-computed vectors for every function code,
// async reset, one-cycle latency and unit-clear behaviour.
module tb_alu_top;

  logic        CLK;
  logic        RST;
  logic [15:0] A;
  logic [15:0] B;
  logic [3:0]  ALU_FUN;
  logic [15:0] Arith_OUT;
  logic        Carry_OUT;
  logic [15:0] Logic_OUT;
  logic [1:0]  CMP_OUT;
  logic [15:0] SHIFT_OUT;
  logic        Arith_Flag;
  logic        Logic_Flag;
  logic        CMP_Flag;
  logic        SHIFT_Flag;

  int errors = 0;
  int checks = 0;

  alu_top dut (
    .CLK(CLK), .RST(RST), .A(A), .B(B), .ALU_FUN(ALU_FUN),
    .Arith_OUT(Arith_OUT), .Carry_OUT(Carry_OUT),
    .Logic_OUT(Logic_OUT), .CMP_OUT(CMP_OUT),
    .SHIFT_OUT(SHIFT_OUT),
    .Arith_Flag(Arith_Flag), .Logic_Flag(Logic_Flag),
    .CMP_Flag(CMP_Flag), .SHIFT_Flag(SHIFT_Flag)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // flags as {Arith,Logic,CMP,SHIFT}
  task automatic chk_all(input string tag, input logic [15:0] ar,
                         input logic c, input logic [15:0] lo,
                         input logic [1:0] cm, input logic [15:0] sh,
                         input logic [3:0] fl);
    chk({tag, ".arith"}, 32'(Arith_OUT), 32'(ar));
    chk({tag, ".carry"}, 32'(Carry_OUT), 32'(c));
    chk({tag, ".logic"}, 32'(Logic_OUT), 32'(lo));
    chk({tag, ".cmp"},   32'(CMP_OUT),   32'(cm));
    chk({tag, ".shift"}, 32'(SHIFT_OUT), 32'(sh));
    chk({tag, ".flags"},
        32'({Arith_Flag, Logic_Flag, CMP_Flag, SHIFT_Flag}), 32'(fl));
  endtask

  task automatic step(input logic [15:0] a, input logic [15:0] b,
                      input logic [3:0] f);
    @(negedge CLK);
    A = a;
    B = b;
    ALU_FUN = f;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    RST = 1'b0;
    A = '0;
    B = '0;
    ALU_FUN = 4'b0000;
    #2;
    chk_all("reset", 0, 0, 0, 0, 0, 4'b1000);
    @(negedge CLK);
    RST = 1'b1;

    step(16'd3, 16'd1, 4'b0000);
    chk_all("add", 16'd4, 0, 0, 0, 0, 4'b1000);
    step(16'd7, 16'd2, 4'b0001);
    chk_all("sub", 16'd5, 0, 0, 0, 0, 4'b1000);
    step(16'd3, 16'd2, 4'b0010);
    chk_all("mul", 16'd6, 0, 0, 0, 0, 4'b1000);
    step(16'd6, 16'd2, 4'b0011);
    chk_all("div", 16'd3, 0, 0, 0, 0, 4'b1000);
    step(16'hFFFF, 16'd1, 4'b0000);
    chk_all("add_carry", 16'd0, 1, 0, 0, 0, 4'b1000);
    step(16'd5, 16'd0, 4'b0011);
    chk_all("div0", 16'd0, 0, 0, 0, 0, 4'b1000);
    step(16'd2, 16'd3, 4'b0001);
    chk_all("sub_borrow", 16'hFFFF, 1, 0, 0, 0, 4'b1000);
    step(16'h0101, 16'h0100, 4'b0010);
    chk_all("mul_trunc", 16'h0100, 0, 0, 0, 0, 4'b1000);

    step(16'd7, 16'd2, 4'b0001);
    chk_all("sub_hold", 16'd5, 0, 0, 0, 0, 4'b1000);
    #2;
    RST = 1'b0;
    #1;
    chk_all("rst_async", 0, 0, 0, 0, 0, 4'b1000);
    @(posedge CLK);
    #1;
    chk_all("rst_held", 0, 0, 0, 0, 0, 4'b1000);
    @(negedge CLK);
    RST = 1'b1;
    #1;
    chk_all("rst_release", 0, 0, 0, 0, 0, 4'b1000);
    @(posedge CLK);
    #1;
    chk_all("rst_first_edge", 16'd5, 0, 0, 0, 0, 4'b1000);

    step(16'd7, 16'hD, 4'b0100);
    chk_all("and", 0, 0, 16'd5, 0, 0, 4'b0100);
    step(16'd3, 16'd5, 4'b0101);
    chk_all("or", 0, 0, 16'd7, 0, 0, 4'b0100);
    step(16'hFFFD, 16'hFFFE, 4'b0110);
    chk_all("nand", 0, 0, 16'd3, 0, 0, 4'b0100);
    step(16'hFFF9, 16'hFFF0, 4'b0111);
    chk_all("nor", 0, 0, 16'd6, 0, 0, 4'b0100);

    step(16'd7, 16'd7, 4'b1000);
    chk_all("cmp_nop", 0, 0, 0, 2'd0, 0, 4'b0010);
    step(16'd7, 16'd7, 4'b1001);
    chk_all("cmp_eq", 0, 0, 0, 2'd1, 0, 4'b0010);
    step(16'd7, 16'd6, 4'b1001);
    chk_all("cmp_eq_false", 0, 0, 0, 2'd0, 0, 4'b0010);
    step(16'd7, 16'd6, 4'b1010);
    chk_all("cmp_gt", 0, 0, 0, 2'd2, 0, 4'b0010);
    step(16'd3, 16'd7, 4'b1011);
    chk_all("cmp_lt", 0, 0, 0, 2'd3, 0, 4'b0010);
    step(16'd7, 16'd6, 4'b1011);
    chk_all("cmp_lt_false", 0, 0, 0, 2'd0, 0, 4'b0010);
    step(16'h8000, 16'h0001, 4'b1010);
    chk_all("cmp_gt_unsigned", 0, 0, 0, 2'd2, 0, 4'b0010);

    step(16'd3, 16'h0010, 4'b1100);
    chk_all("shr_a", 0, 0, 0, 0, 16'd1, 4'b0001);
    step(16'd3, 16'h0010, 4'b1101);
    chk_all("shl_a", 0, 0, 0, 0, 16'd6, 4'b0001);
    step(16'h0010, 16'd3, 4'b1110);
    chk_all("shr_b", 0, 0, 0, 0, 16'd1, 4'b0001);
    step(16'h0010, 16'd3, 4'b1111);
    chk_all("shl_b", 0, 0, 0, 0, 16'd6, 4'b0001);
    step(16'h8001, 16'h0010, 4'b1101);
    chk_all("shl_msb_drop", 0, 0, 0, 0, 16'h0002, 4'b0001);
    step(16'h0010, 16'h8001, 4'b1110);
    chk_all("shr_b_msb", 0, 0, 0, 0, 16'h4000, 4'b0001);

    @(negedge CLK);
    A = 16'd7;
    B = 16'hD;
    ALU_FUN = 4'b0100;
    #1;
    chk_all("lat_before_edge", 0, 0, 0, 0, 16'h4000, 4'b0100);
    @(posedge CLK);
    #1;
    chk_all("lat_after_edge", 0, 0, 16'd5, 0, 0, 4'b0100);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/alu_top.md
Name: alu_top

Overview:
- 16-bit registered ALU with four function units: arithmetic, logic, compare and shift.
- A 4-bit function code selects the operation. ALU_FUN[3:2] picks the unit; ALU_FUN[1:0] picks the operation within it.
- Each unit drives its own registered output bus plus a combinational "unit active" flag.
- Sits in the system datapath between the register file and the operand/result bus; single clock domain.

Parameters:
- in_width, 16, operand width of A and B.
- out_width, 16, width of the Arith_OUT, Logic_OUT and SHIFT_OUT result buses.

Ports:
- CLK  in  1  system clock; rising edge active.
- RST  in  1  asynchronous, active-low reset.
- A  in  in_width  operand A (unsigned).
- B  in  in_width  operand B (unsigned).
- ALU_FUN  in  4  function select.
- Arith_OUT  out  out_width  registered arithmetic result.
- Carry_OUT  out  1  registered carry/borrow of add/sub.
- Logic_OUT  out  out_width  registered logic result.
- CMP_OUT  out  2  registered compare code.
- SHIFT_OUT  out  out_width  registered shift result.
- Arith_Flag  out  1  high when ALU_FUN[3:2]=00.
- Logic_Flag  out  1  high when ALU_FUN[3:2]=01.
- CMP_Flag  out  1  high when ALU_FUN[3:2]=10.
- SHIFT_Flag  out  1  high when ALU_FUN[3:2]=11.

Behaviour:
- Unit decode is combinational. The four flags are one-hot decodes of ALU_FUN[3:2] and are independent of reset and clock.
- Result registers: all result outputs are flops updated on the rising CLK edge. Latency is 1 cycle from A/B/ALU_FUN to output.
- Unselected units: on every edge, each unselected unit's registers load 0. Only the selected unit's bus is non-zero.
- Reset: while RST=0, all registered outputs are 0 asynchronously (Arith_OUT, Carry_OUT, Logic_OUT, CMP_OUT, SHIFT_OUT). Reset mid-operation discards the pending result. The first edge after RST rises loads the current operation.
- Arithmetic, 00xx:
  - 0000: A+B. Carry_OUT = bit 16 of the 17-bit sum.
  - 0001: A-B, modulo 2^16. Carry_OUT = 1 on borrow (A<B).
  - 0010: A*B, lower 16 bits. Carry_OUT = 0.
  - 0011: A/B, integer quotient. Carry_OUT = 0. B=0 gives Arith_OUT=0.
- Logic, 01xx (bitwise):
  - 0100: A&B.
  - 0101: A|B.
  - 0110: ~(A&B).
  - 0111: ~(A|B).
- Compare, 10xx (unsigned). The code is produced only when the tested relation is true, otherwise 0:
  - 1000: NOP, CMP_OUT=0.
  - 1001: A==B gives 1.
  - 1010: A>B gives 2.
  - 1011: A<B gives 3.
- Shift, 11xx (logical, by one bit, zero fill):
  - 1100: A>>1.
  - 1101: A<<1, MSB dropped.
  - 1110: B>>1.
  - 1111: B<<1, MSB dropped.
- Width rules: all results are truncated to out_width; no saturation.
- X/undefined ALU_FUN: treat as a don't-care. Implement using a full case with all registers defaulting to 0.

Test Plan:
- Arithmetic:
  - A=3, B=1, FUN=0000, 1 edge -> Arith_OUT=4, Carry_OUT=0, Arith_Flag=1.
  - A=7, B=2, FUN=0001 -> 5.
  - A=3, B=2, FUN=0010 -> 6.
  - A=6, B=2, FUN=0011 -> 3.
  - A=0xFFFF, B=1, FUN=0000 -> Arith_OUT=0, Carry_OUT=1.
  - B=0, FUN=0011 -> 0.
- Reset: after a subtraction result is held, pulse RST low between edges -> all registered outputs read 0 immediately and stay 0 until the next edge.
- Logic:
  - A=7, B=0xD, FUN=0100 -> Logic_OUT=5, Logic_Flag=1, Arith_OUT=0.
  - A=3, B=5, FUN=0101 -> 7.
  - A=0xFFFD, B=0xFFFE, FUN=0110 -> 3.
  - A=0xFFF9, B=0xFFF0, FUN=0111 -> 6.
- Compare:
  - FUN=1000 -> CMP_OUT=0, CMP_Flag=1.
  - A=B=7, FUN=1001 -> 1.
  - A=7, B=6, FUN=1010 -> 2.
  - A=3, B=7, FUN=1011 -> 3.
  - A=7, B=6, FUN=1011 -> 0.
- Shift:
  - A=3, FUN=1100 -> SHIFT_OUT=1, SHIFT_Flag=1.
  - A=3, FUN=1101 -> 6.
  - B=3, FUN=1110 -> 1.
  - B=3, FUN=1111 -> 6.
  - A=0x8001, FUN=1101 -> 0x0002.
- Flag/latency: change ALU_FUN between edges -> flags switch immediately; result buses change only at the next rising edge, and the previous unit's bus clears to 0.
